// File: rtl/acc_result_pack.sv
// Requantizes accumulator results (rounding shift + saturation), packs C_PACK lanes
// per word and buffers packed words in a small FWFT FIFO; dropped words set a sticky flag.
module acc_result_pack #(
  parameter int C_IN    = 13,
  parameter int C_OUT   = 8,
  parameter int C_SHIFT = 4,
  parameter int C_PACK  = 4,
  parameter int C_DEPTH = 4
) (
  input  logic                        I_clk,
  input  logic                        I_rst,
  input  logic                        I_result_rdy,
  input  logic [C_IN-1:0]             I_result,
  input  logic [C_SHIFT-1:0]          I_shift,
  input  logic                        I_flush,
  output logic                        O_data_valid,
  input  logic                        I_data_ready,
  output logic [C_PACK*C_OUT-1:0]     O_data,
  output logic [$clog2(C_DEPTH):0]    O_count,
  output logic                        O_overflow
);

  localparam int XW = C_IN + 1;
  localparam int CW = $clog2(C_PACK);
  localparam int PW = $clog2(C_DEPTH);
  localparam int WW = C_PACK * C_OUT;
  localparam logic signed [XW-1:0] SAT_MAX = XW'((1 << (C_OUT - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_MIN = XW'(-(1 << (C_OUT - 1)));
  localparam logic [CW-1:0]        LANE_LAST = CW'(C_PACK - 1);
  localparam logic [PW:0]          CNT_FULL  = (PW + 1)'(C_DEPTH);

  // Stage 1: quantize
  logic signed [XW-1:0] w_x, w_rnd, w_sum, w_shr;
  logic [C_OUT-1:0]     w_q;
  logic [C_OUT-1:0]     r_q;
  logic                 r_q_valid;
  logic                 r_flush_d;

  // One extra bit of headroom keeps the rounding add from wrapping.
  always_comb begin
    w_x   = {I_result[C_IN-1], I_result};
    w_rnd = '0;
    if (I_shift != '0) w_rnd = XW'(1) << (I_shift - 1'b1);
    w_sum = w_x + w_rnd;
    w_shr = w_sum >>> I_shift;
    if (w_shr > SAT_MAX)      w_q = SAT_MAX[C_OUT-1:0];
    else if (w_shr < SAT_MIN) w_q = SAT_MIN[C_OUT-1:0];
    else                      w_q = w_shr[C_OUT-1:0];
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_flush_d <= 1'b0;
    end else begin
      r_q       <= w_q;
      r_q_valid <= I_result_rdy;
      r_flush_d <= I_flush;
    end
  end

  // Stage 2: pack. A non-zero lane counter means the packer holds lanes.
  logic [CW-1:0] r_lane;
  logic [WW-1:0] r_pack;
  logic [WW-1:0] w_word;
  logic          w_complete;

  always_comb begin
    w_word = r_pack;
    if (r_q_valid) w_word[r_lane*C_OUT +: C_OUT] = r_q;
    w_complete = (r_q_valid && (r_lane == LANE_LAST)) ||
                 (r_flush_d && (r_q_valid || (r_lane != '0)));
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_lane <= '0;
      r_pack <= '0;
    end else if (w_complete) begin
      r_lane <= '0;
      r_pack <= '0;
    end else if (r_q_valid) begin
      r_lane <= r_lane + 1'b1;
      r_pack <= w_word;
    end
  end

  // FIFO. Handshake: a word transfers on a rising edge where O_data_valid && I_data_ready;
  // O_data/O_data_valid depend only on FIFO state, never on I_data_ready.
  logic [WW-1:0] r_mem [C_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_overflow;
  logic          w_full, w_pop, w_push, w_drop;

  always_comb begin
    w_full = (r_count == CNT_FULL);
    w_pop  = (r_count != '0) && I_data_ready;
    w_push = w_complete && (!w_full || w_pop);
    w_drop = w_complete && w_full && !w_pop;
  end

  always_ff @(posedge I_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_comb begin
    O_data_valid = (r_count != '0);
    O_data       = O_data_valid ? r_mem[r_rd_ptr] : '0;
    O_count      = r_count;
    O_overflow   = r_overflow;
  end

endmodule

// File: tb/tb_acc_result_pack.sv
// Directed bench for acc_result_pack: table of full-word vectors plus flush,
// backpressure/overflow and mid-operation reset sequences.
module tb_acc_result_pack;

  localparam int C_IN    = 13;
  localparam int C_OUT   = 8;
  localparam int C_SHIFT = 4;
  localparam int C_PACK  = 4;
  localparam int C_DEPTH = 4;

  logic                     I_clk;
  logic                     I_rst;
  logic                     I_result_rdy;
  logic [C_IN-1:0]          I_result;
  logic [C_SHIFT-1:0]       I_shift;
  logic                     I_flush;
  logic                     O_data_valid;
  logic                     I_data_ready;
  logic [C_PACK*C_OUT-1:0]  O_data;
  logic [$clog2(C_DEPTH):0] O_count;
  logic                     O_overflow;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  acc_result_pack #(
    .C_IN(C_IN), .C_OUT(C_OUT), .C_SHIFT(C_SHIFT), .C_PACK(C_PACK), .C_DEPTH(C_DEPTH)
  ) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_result_rdy(I_result_rdy), .I_result(I_result),
    .I_shift(I_shift), .I_flush(I_flush), .O_data_valid(O_data_valid),
    .I_data_ready(I_data_ready), .O_data(O_data), .O_count(O_count), .O_overflow(O_overflow)
  );

  // clock / reset
  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  typedef struct {
    string       name;
    logic [3:0]  shift;
    int          r[4];
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[6];

  // driver tasks: inputs change and outputs are sampled at the falling edge
  task automatic step();
    @(posedge I_clk);
    @(negedge I_clk);
  endtask

  task automatic send(input int v);
    I_result_rdy = 1'b1;
    I_result     = 13'(v);
    step();
    I_result_rdy = 1'b0;
  endtask

  task automatic pop_one();
    I_data_ready = 1'b1;
    step();
    I_data_ready = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic set_vec(input int idx, input string name, input logic [3:0] sh,
                         input int a, input int b, input int c, input int d,
                         input logic [31:0] w);
    vecs[idx].name     = name;
    vecs[idx].shift    = sh;
    vecs[idx].r[0]     = a;
    vecs[idx].r[1]     = b;
    vecs[idx].r[2]     = c;
    vecs[idx].r[3]     = d;
    vecs[idx].exp_word = w;
  endtask

  initial begin
    set_vec(0, "basic",     4'd0,  1,    2,     3,    4,     32'h04030201);
    set_vec(1, "sat_s0",    4'd0,  4095, -4096, 127,  -128,  32'h807F807F);
    set_vec(2, "round_s2",  4'd2,  6,    5,     -6,   -7,    32'hFEFF0102);
    set_vec(3, "round_s4",  4'd4,  8,    7,     -8,   2047,  32'h7F000001);
    set_vec(4, "round_s12", 4'd12, 4095, -4096, 2048, -2049, 32'hFF01FF01);
    set_vec(5, "sat_s1",    4'd1,  3,    -3,    255,  -257,  32'h807FFF02);

    I_rst = 1'b1; I_result_rdy = 1'b0; I_result = '0; I_shift = '0;
    I_flush = 1'b0; I_data_ready = 1'b0;
    step();
    step();
    I_rst = 1'b0;
    check("rst_valid", 32'(O_data_valid), 32'd0);
    check("rst_count", 32'(O_count), 32'd0);
    check("rst_ovf",   32'(O_overflow), 32'd0);
    check("rst_data",  O_data, 32'd0);

    // table-driven full words
    foreach (vecs[i]) begin
      I_shift = vecs[i].shift;
      for (int k = 0; k < 4; k++) send(vecs[i].r[k]);
      check({vecs[i].name, "_lat"}, 32'(O_data_valid), 32'd0);
      step();
      check({vecs[i].name, "_valid"}, 32'(O_data_valid), 32'd1);
      check({vecs[i].name, "_data"}, O_data, vecs[i].exp_word);
      check({vecs[i].name, "_count"}, 32'(O_count), 32'd1);
      pop_one();
      check({vecs[i].name, "_pop"}, 32'(O_count), 32'd0);
    end

    // flush of a partial word
    I_shift = 4'd0;
    send(9);
    send(10);
    I_flush = 1'b1;
    step();
    I_flush = 1'b0;
    check("flush_lat", 32'(O_data_valid), 32'd0);
    step();
    check("flush_valid", 32'(O_data_valid), 32'd1);
    check("flush_data", O_data, 32'h00000A09);
    check("flush_count", 32'(O_count), 32'd1);
    // flush with empty packer: no push
    I_flush = 1'b1;
    step();
    I_flush = 1'b0;
    step();
    step();
    check("flush_empty_count", 32'(O_count), 32'd1);
    pop_one();
    check("flush_pop", 32'(O_count), 32'd0);

    // flush together with the completing 4th lane: exactly one word
    send(11);
    send(12);
    send(13);
    I_result_rdy = 1'b1; I_result = 13'd14; I_flush = 1'b1;
    step();
    I_result_rdy = 1'b0; I_flush = 1'b0;
    step();
    check("flush4_count", 32'(O_count), 32'd1);
    check("flush4_data", O_data, 32'h0E0D0C0B);
    step();
    step();
    check("flush4_once", 32'(O_count), 32'd1);
    pop_one();
    check("flush4_pop", 32'(O_count), 32'd0);

    // backpressure: 5 words into a 4-deep FIFO
    I_data_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 17) check("bp_no_ovf_yet", 32'(O_overflow), 32'd0);
      send(i);
    end
    for (int j = 0; j < 4; j++)
      exp_q.push_back({8'(4*j+4), 8'(4*j+3), 8'(4*j+2), 8'(4*j+1)});
    step();
    step();
    check("bp_count", 32'(O_count), 32'd4);
    check("bp_ovf", 32'(O_overflow), 32'd1);
    I_data_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check("drain_valid", 32'(O_data_valid), 32'd1);
      check("drain_data", O_data, e);
      step();
    end
    I_data_ready = 1'b0;
    check("drain_empty", 32'(O_data_valid), 32'd0);
    check("drain_count", 32'(O_count), 32'd0);
    check("drain_ovf_sticky", 32'(O_overflow), 32'd1);

    // reset mid-operation: one word queued plus two lanes packed
    for (int i = 1; i <= 6; i++) send(i);
    step();
    step();
    check("pre_rst_count", 32'(O_count), 32'd1);
    I_rst = 1'b1;
    step();
    I_rst = 1'b0;
    check("mid_rst_valid", 32'(O_data_valid), 32'd0);
    check("mid_rst_count", 32'(O_count), 32'd0);
    check("mid_rst_ovf",   32'(O_overflow), 32'd0);
    check("mid_rst_data",  O_data, 32'd0);
    for (int i = 5; i <= 8; i++) send(i);
    step();
    check("post_rst_data", O_data, 32'h08070605);
    check("post_rst_count", 32'(O_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_result_pack.md
# acc_result_pack

Downstream receiver for the pipelined accumulator's result interface (result-ready pulse plus result word). Takes each accumulated sum, requantizes it with a programmable rounding right-shift and saturation, and packs C_PACK consecutive results into one wide word. Packed words go into a small first-word-fall-through FIFO drained by a valid/ready handshake toward the output buffer or DDR writer. Any accumulator result that cannot be stored is counted as lost via a sticky overflow flag; nothing stalls the accumulator.

## Interface
Parameters:
- C_IN, 13, width of the incoming accumulator result (signed two's complement)
- C_OUT, 8, width of one quantized lane (signed)
- C_SHIFT, 4, width of the shift-amount input
- C_PACK, 4, lanes per packed word (≥2)
- C_DEPTH, 4, FIFO depth in packed words (power of 2, ≥2)

Ports:
- I_clk  in  1  single clock; all logic on rising edge
- I_rst  in  1  reset, synchronous, active-high
- I_result_rdy  in  1  one-cycle strobe; I_result valid this cycle
- I_result  in  C_IN  accumulator sum, signed
- I_shift  in  C_SHIFT  right-shift amount; quasi-static, 0..C_IN-1
- I_flush  in  1  one-cycle strobe; emit partial word zero-padded
- O_data_valid  out  1  FIFO head valid (count != 0)
- I_data_ready  in  1  downstream accepts head this cycle
- O_data  out  C_PACK*C_OUT  FIFO head; lane k at bits [k*C_OUT +: C_OUT], lane 0 = first result
- O_count  out  log2(C_DEPTH)+1  FIFO occupancy
- O_overflow  out  1  sticky; a completed word was dropped

## Operation
- Stage 1, quantize (registered): x = I_result sign-extended to C_IN+1 bits. If I_shift>0, add 2^(I_shift-1) (round half up), then arithmetic shift right by I_shift. Saturate to [-2^(C_OUT-1), 2^(C_OUT-1)-1]. Register q and q_valid = I_result_rdy. Register I_flush alongside as flush_d, so a flush applies after every result accepted in the same or an earlier cycle.
- Stage 2, pack:
  - Lane counter runs 0..C_PACK-1. A q_valid writes q into the lane selected by the counter.
  - Word complete when q_valid arrives at lane C_PACK-1, or when flush_d is high and the word holds at least one lane (including a lane written in the same cycle).
  - On completion: push the word with unwritten lanes = 0, clear the pack register, set the counter to 0.
  - flush_d with an empty packer and no q_valid does nothing.
- FIFO:
  - Push on word complete. Pop when O_data_valid && I_data_ready.
  - Push while full with a simultaneous pop is accepted.
  - Push while full without a pop: the word is discarded, O_overflow is set and held until reset, and FIFO contents are unchanged.
  - Pop while empty is ignored.
  - Read and write pointers wrap modulo C_DEPTH; O_count is kept separately to tell full from empty.
- I_shift changes take effect on the next accepted result; no re-alignment of already-quantized lanes.
- Reset (I_rst=1 at an edge): lane counter, pack register, stage-1 regs, pointers and count go to 0; O_overflow=0. Outputs after reset: O_data_valid=0, O_count=0, O_overflow=0, O_data=0. Reset mid-word discards partial lanes and all FIFO contents.

## Timing
- Latency: the I_result_rdy of a completing lane sampled at edge t → stage-1 register at t+1 → FIFO write at t+2. O_data_valid rises after edge t+2 if the FIFO was empty.
- Flush: I_flush at edge t → partial word written at edge t+2.
- Throughput: one result per cycle sustained; one packed word per C_PACK cycles; the FIFO pops one word per cycle.
- O_data and O_data_valid change only after a clock edge; they are combinational from FIFO state only, with no path from I_data_ready.
- O_count updates on the same edge as the push/pop; simultaneous push and pop leaves it unchanged.

## Test plan
With defaults C_IN=13, C_OUT=8, C_PACK=4, C_DEPTH=4:
- shift=0, results 1,2,3,4 on consecutive cycles → O_data=32'h04030201, O_data_valid high 2 cycles after the strobe carrying 4, O_count=1.
- Saturation, shift=0: 4095, -4096, 127, -128 → O_data=32'h807F807F.
- Rounding, shift=2: 6, 5, -6, -7 → lanes 2, 1, -1, -2 → O_data=32'hFEFF0102.
- Flush, shift=0: 9, 10, then I_flush → O_data=32'h00000A09. A second flush with the packer empty → no push, O_count unchanged. A flush on the same cycle as a 4th lane → exactly one word.
- Backpressure: I_data_ready=0, 20 results (5 words) → O_count=4, O_overflow=1, 5th word lost. Then I_data_ready=1 → 4 words drain in order, one per cycle, and O_overflow stays 1.
- Reset mid-operation: 1 word in FIFO plus 2 lanes packed, pulse I_rst → all outputs 0. The next results 5,6,7,8 → O_data=32'h08070605.
